framebuffer_init: RTL and testbench
===================================

FRAMEBUFFER_INIT -- requirements
Module: framebuffer_init

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the framebuffer address width; clear range is 0 to 2^ADDR_WIDTH-1.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the write data width.
REQ-003 Parameter CLEAR_VALUE, default 0, SHALL be the word written to every address.
REQ-004 Parameter SETTLE_CYCLES, default 8, range 0..255, SHALL be the idle delay after reset release before clearing starts.
REQ-005 clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset, driven by the power-on reset generator.
REQ-007 start_clear  input  1  runtime request to re-clear the framebuffer.
REQ-008 wr_ready  input  1  memory arbiter accepts a write this cycle.
REQ-009 wr_en  output  1  write request.
REQ-010 wr_addr  output  ADDR_WIDTH  write address.
REQ-011 wr_data  output  DATA_WIDTH  write data; constant CLEAR_VALUE.
REQ-012 busy  output  1  high in SETTLE or CLEAR.
REQ-013 ready  output  1  high only in DONE; display pipeline is gated on it.
REQ-014 done_pulse  output  1  one-cycle strobe on each CLEAR-to-DONE transition.

Function
REQ-015 The block SHALL implement three states: SETTLE, CLEAR and DONE.
REQ-016 In SETTLE, a counter SHALL increment once per cycle and the state SHALL move to CLEAR on the edge after the counter reaches SETTLE_CYCLES-1.
REQ-017 With SETTLE_CYCLES=0, the block SHALL enter CLEAR on the first clock edge after reset release.
REQ-018 On entry to CLEAR, wr_addr SHALL be 0 and wr_en SHALL be 1 from the first CLEAR cycle.
REQ-019 A write SHALL complete only in a cycle where wr_en and wr_ready are both 1; on completion, wr_addr SHALL increment by 1 on the next edge.
REQ-020 While wr_ready=0, wr_en, wr_addr and wr_data SHALL hold their values unchanged.
REQ-021 When the write to address 2^ADDR_WIDTH-1 completes, the block SHALL enter DONE on the next edge and set wr_en=0, ready=1, done_pulse=1 for that one cycle.
REQ-022 wr_addr SHALL NOT wrap during CLEAR; it SHALL return to 0 in DONE.
REQ-023 start_clear SHALL be ignored in SETTLE and CLEAR.
REQ-024 start_clear=1 in DONE SHALL, on the next edge, enter CLEAR with wr_addr=0, ready=0 and busy=1.
REQ-025 start_clear asserted in the same cycle as the final CLEAR write SHALL be ignored; DONE is still entered.
REQ-026 A full clear with wr_ready held at 1 SHALL take exactly 2^ADDR_WIDTH cycles in CLEAR.
REQ-027 All outputs SHALL be driven from registers, with no combinational path from any input to any output.

Reset
REQ-028 reset=1 SHALL immediately set state=SETTLE, settle counter=0, wr_en=0, wr_addr=0, ready=0, done_pulse=0 and busy=1, regardless of clk_in.
REQ-029 reset asserted mid-CLEAR SHALL abort the sweep; after release, the full SETTLE-then-CLEAR sequence SHALL restart from address 0.
REQ-030 wr_data SHALL equal CLEAR_VALUE at all times, including during reset.

Structure
REQ-031 State encodings (SETTLE=2'd0, CLEAR=2'd1, DONE=2'd2) SHALL be defined in the shared project constants package for reuse by the display controller.
REQ-032 The SETTLE delay SHALL be built from one timeout_sync instance, named settle_timer, with COUNTER_WIDTH=8 and value=SETTLE_CYCLES; the FSM and address counter SHALL be local.

Verification
REQ-033 ADDR_WIDTH=4, SETTLE_CYCLES=8, wr_ready=1, reset pulsed 3 cycles -> first wr_en=1 8 cycles after release; addresses 0..15 in 16 consecutive cycles; done_pulse for 1 cycle; ready=1.
REQ-034 ADDR_WIDTH=4, wr_ready low on every second cycle -> each address appears exactly once, held for 2 cycles; CLEAR lasts 32 cycles.
REQ-035 Reset asserted when wr_addr=7 -> all outputs at reset values asynchronously; after release, the sweep restarts at address 0 after 8 settle cycles.
REQ-036 In DONE, start_clear=1 for 1 cycle -> ready=0 next cycle and a second 16-address sweep; start_clear during the sweep produces no effect.
REQ-037 SETTLE_CYCLES=0 -> wr_en=1 with wr_addr=0 on the first cycle after reset release.
REQ-038 start_clear=1 coincident with the address-15 write -> DONE entered, single done_pulse, no new sweep.

Source files
------------

// File: rtl/framebuffer_init_pkg.sv
// Shared constants for the framebuffer power-up clear logic.
// The state encoding is also consumed by the display controller.
package framebuffer_init_pkg;

  typedef enum logic [1:0] {
    FB_SETTLE = 2'd0,
    FB_CLEAR  = 2'd1,
    FB_DONE   = 2'd2
  } fb_state_e;

  // Width of the post-reset settle counter
  localparam int unsigned SETTLE_TIMER_WIDTH = 8;

  // The block reports busy in every state except the finished one
  function automatic logic fb_busy(input fb_state_e state);
    return (state != FB_DONE);
  endfunction

endpackage

// File: rtl/framebuffer_init_if.sv
// Write port between the framebuffer clearer and the memory arbiter.
interface framebuffer_init_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/timeout_sync.sv
// Cycle timer: counts clock cycles while run is high and flags when the
// programmed number of cycles has elapsed. A value of zero is expired at once.
module timeout_sync #(
  parameter int unsigned COUNTER_WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     run,
  input  logic [COUNTER_WIDTH-1:0] value,
  output logic                     expired
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNTER_WIDTH-1:0] count_r;

  assign expired = (value == CNT_ZERO) || (count_r == (value - CNT_ONE));

  // Cycle counter: cleared when idle, saturates once the timeout is reached
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else if (!run) begin
      count_r <= CNT_ZERO;
    end else if (!expired) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/framebuffer_init.sv
// Framebuffer initialiser: waits a settle period after reset, then sweeps
// every framebuffer address writing CLEAR_VALUE, and raises ready when done.
// A runtime re-clear can be requested once the first sweep has finished.
module framebuffer_init
  import framebuffer_init_pkg::*;
#(
  parameter int unsigned                 ADDR_WIDTH    = 11,
  parameter int unsigned                 DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0]       CLEAR_VALUE   = {DATA_WIDTH{1'b0}},
  parameter int unsigned                 SETTLE_CYCLES = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                start_clear,
  framebuffer_init_if.master  wr_bus,
  output logic                busy,
  output logic                ready,
  output logic                done_pulse
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [SETTLE_TIMER_WIDTH-1:0] SETTLE_VALUE =
    SETTLE_TIMER_WIDTH'(SETTLE_CYCLES);

  fb_state_e             state_r;
  fb_state_e             state_s;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic                  wr_en_r;
  logic                  busy_r;
  logic                  ready_r;
  logic                  done_pulse_r;
  logic                  done_pulse_s;
  logic                  settle_expired_s;
  logic                  write_fire_s;

  timeout_sync #(
    .COUNTER_WIDTH (SETTLE_TIMER_WIDTH)
  ) settle_timer (
    .clk_in  (clk_in),
    .reset   (reset),
    .run     (state_r == FB_SETTLE),
    .value   (SETTLE_VALUE),
    .expired (settle_expired_s)
  );

  assign write_fire_s = wr_en_r & wr_bus.wr_ready;

  // Next-state and next-address decode; address only moves on an accepted write
  always_comb begin
    state_s      = state_r;
    wr_addr_s    = wr_addr_r;
    done_pulse_s = 1'b0;
    case (state_r)
      FB_SETTLE: begin
        if (settle_expired_s) begin
          state_s   = FB_CLEAR;
          wr_addr_s = ADDR_ZERO;
        end else begin
          state_s   = FB_SETTLE;
        end
      end
      FB_CLEAR: begin
        if (write_fire_s) begin
          if (wr_addr_r == ADDR_LAST) begin
            // Last write accepted: a pending start_clear is deliberately ignored
            state_s      = FB_DONE;
            wr_addr_s    = ADDR_ZERO;
            done_pulse_s = 1'b1;
          end else begin
            wr_addr_s    = wr_addr_r + ADDR_ONE;
          end
        end else begin
          wr_addr_s = wr_addr_r;
        end
      end
      FB_DONE: begin
        wr_addr_s = ADDR_ZERO;
        if (start_clear) begin
          state_s = FB_CLEAR;
        end else begin
          state_s = FB_DONE;
        end
      end
      default: begin
        state_s   = FB_SETTLE;
        wr_addr_s = ADDR_ZERO;
      end
    endcase
  end

  // State and output registers; every output is a flop decoded from next state
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r      <= FB_SETTLE;
      wr_addr_r    <= ADDR_ZERO;
      wr_en_r      <= 1'b0;
      busy_r       <= 1'b1;
      ready_r      <= 1'b0;
      done_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      wr_addr_r    <= wr_addr_s;
      wr_en_r      <= (state_s == FB_CLEAR);
      busy_r       <= fb_busy(state_s);
      ready_r      <= (state_s == FB_DONE);
      done_pulse_r <= done_pulse_s;
    end
  end

  assign wr_bus.wr_en   = wr_en_r;
  assign wr_bus.wr_addr = wr_addr_r;
  assign wr_bus.wr_data = CLEAR_VALUE;
  assign busy           = busy_r;
  assign ready          = ready_r;
  assign done_pulse     = done_pulse_r;

endmodule

// File: tb/tb_framebuffer_init.sv
// Bench for framebuffer_init: two instances (settle 8 and settle 0) share the
// stimulus; a behavioural model predicts every output on every cycle, and
// directed phases pin latencies and corner cases with literal expectations.
module tb_framebuffer_init;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] CV0 = 16'hA5C3;
  localparam logic [DW-1:0] CV1 = 16'h0000;

  logic clk_in      = 1'b0;
  logic reset       = 1'b1;
  logic start_clear = 1'b0;
  logic wr_ready    = 1'b1;
  logic busy0, ready0, pulse0, busy1, ready1, pulse1;

  framebuffer_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  framebuffer_init_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  assign bus0.wr_ready = wr_ready;
  assign bus1.wr_ready = wr_ready;

  framebuffer_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CV0), .SETTLE_CYCLES(8)) dut0 (
    .clk_in(clk_in), .reset(reset), .start_clear(start_clear), .wr_bus(bus0.master),
    .busy(busy0), .ready(ready0), .done_pulse(pulse0));

  framebuffer_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CV1), .SETTLE_CYCLES(0)) dut1 (
    .clk_in(clk_in), .reset(reset), .start_clear(start_clear), .wr_bus(bus1.master),
    .busy(busy1), .ready(ready1), .done_pulse(pulse1));

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Behavioural model: settle countdown, then one write per accepted cycle
  int settle_of[2] = '{8, 0};
  int m_left[2];
  int m_addr[2];
  bit m_clr[2];
  bit m_done[2];
  bit m_pulse[2];

  always @(posedge clk_in or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_left[k] <= settle_of[k]; m_addr[k] <= 0;
        m_clr[k] <= 1'b0; m_done[k] <= 1'b0; m_pulse[k] <= 1'b0;
      end else begin
        m_pulse[k] <= 1'b0;
        if (m_done[k]) begin
          if (start_clear) begin
            m_done[k] <= 1'b0; m_clr[k] <= 1'b1; m_addr[k] <= 0;
          end
        end else if (m_clr[k]) begin
          if (wr_ready) begin
            if (m_addr[k] == DEPTH - 1) begin
              m_clr[k] <= 1'b0; m_done[k] <= 1'b1; m_pulse[k] <= 1'b1; m_addr[k] <= 0;
            end else begin
              m_addr[k] <= m_addr[k] + 1;
            end
          end
        end else begin
          if (m_left[k] <= 1) begin
            m_clr[k] <= 1'b1; m_addr[k] <= 0;
          end else begin
            m_left[k] <= m_left[k] - 1;
          end
        end
      end
    end
  end

  task automatic check_dut(input int k, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic b, input logic r,
                           input logic p, input logic [DW-1:0] cv);
    logic [AW-1:0] ea;
    ea = m_addr[k][AW-1:0];
    total++;
    if (we !== m_clr[k] || a !== ea || d !== cv || b !== !m_done[k] ||
        r !== m_done[k] || p !== m_pulse[k]) begin
      bad++;
      $display("FAIL model_dut%0d t=%0t: got en=%b addr=%0d data=%h busy=%b ready=%b pulse=%b want en=%b addr=%0d data=%h busy=%b ready=%b pulse=%b",
               k, $time, we, a, d, b, r, p, m_clr[k], ea, cv, !m_done[k], m_done[k], m_pulse[k]);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(posedge clk_in) begin
    #2;
    check_dut(0, bus0.wr_en, bus0.wr_addr, bus0.wr_data, busy0, ready0, pulse0, CV0);
    check_dut(1, bus1.wr_en, bus1.wr_addr, bus1.wr_data, busy1, ready1, pulse1, CV1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #3;
  endtask

  // Counts cycles until dut0 first shows wr_en after reset release
  task automatic settle_count(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus0.wr_en === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Enters CLEAR from DONE and fixes wr_ready for the first CLEAR cycle
  task automatic begin_sweep(input logic first_ready);
    start_clear = 1'b1;
    tick();
    start_clear = 1'b0;
    wr_ready    = first_ready;
    chk("restart_ready", int'(ready0), 0);
    chk("restart_busy", int'(busy0), 1);
    chk("restart_addr", int'(bus0.wr_addr), 0);
  endtask

  // Runs the sweep to completion; mode 0: ready high, 1: low on odd cycles, 2: random
  task automatic run_sweep(input int mode, output int len);
    len = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus0.wr_en !== 1'b1) break;
      len++;
      start_clear = ($urandom_range(0, 2) == 0);
      if (mode == 0) wr_ready = 1'b1;
      else if (mode == 1) wr_ready = (len % 2 == 0);
      else wr_ready = $urandom_range(0, 1);
    end
    start_clear = 1'b0;
    wr_ready    = 1'b1;
    chk("sweep_done_pulse", int'(pulse0), 1);
    chk("sweep_done_ready", int'(ready0), 1);
  endtask

  initial begin
    int n;
    int len;

    // Power-on reset for three cycles
    repeat (3) tick();
    chk("rst_wr_en", int'(bus0.wr_en), 0);
    chk("rst_busy", int'(busy0), 1);
    chk("rst_ready", int'(ready0), 0);
    chk("rst_data", int'(bus0.wr_data), int'(CV0));
    reset = 1'b0;

    // Settle 8 on dut0; settle 0 on dut1 writes address 0 right away
    tick();
    chk("settle0_wr_en", int'(bus1.wr_en), 1);
    chk("settle0_addr", int'(bus1.wr_addr), 0);
    settle_count(n);
    chk("settle8_latency", n + 1, 8);
    chk("first_addr", int'(bus0.wr_addr), 0);
    run_sweep(0, len);
    chk("sweep_len_full", len, 16);
    tick();
    chk("pulse_one_cycle", int'(pulse0), 0);
    chk("ready_held", int'(ready0), 1);

    // Re-clear request with noise on start_clear during the sweep
    begin_sweep(1'b1);
    run_sweep(0, len);
    chk("reclear_len", len, 16);

    // Arbiter stalls every other cycle: each address held two cycles
    tick();
    begin_sweep(1'b0);
    run_sweep(1, len);
    chk("stall_len", len, 32);

    // start_clear coincident with the final write is ignored
    tick();
    begin_sweep(1'b1);
    for (int i = 0; i < 40; i++) begin
      if (m_clr[0] && m_addr[0] == DEPTH - 1) break;
      tick();
    end
    chk("at_last_addr", int'(bus0.wr_addr), DEPTH - 1);
    start_clear = 1'b1;
    tick();
    start_clear = 1'b0;
    chk("coinc_pulse", int'(pulse0), 1);
    chk("coinc_wr_en", int'(bus0.wr_en), 0);
    tick();
    chk("coinc_no_sweep", int'(bus0.wr_en), 0);
    chk("coinc_ready", int'(ready0), 1);

    // Reset in the middle of a sweep at address 7
    begin_sweep(1'b1);
    for (int i = 0; i < 40; i++) begin
      if (m_clr[0] && m_addr[0] == 7) break;
      tick();
    end
    chk("mid_addr", int'(bus0.wr_addr), 7);
    reset = 1'b1;
    #1;
    chk("async_wr_en", int'(bus0.wr_en), 0);
    chk("async_addr", int'(bus0.wr_addr), 0);
    chk("async_busy", int'(busy0), 1);
    chk("async_ready", int'(ready0), 0);
    tick();
    tick();
    reset = 1'b0;
    settle_count(n);
    chk("resettle_latency", n, 8);
    chk("resettle_addr", int'(bus0.wr_addr), 0);
    run_sweep(0, len);
    chk("resweep_len", len, 16);

    // Random traffic: stalls, re-clear requests and occasional resets
    for (int i = 0; i < 600; i++) begin
      tick();
      wr_ready    = $urandom_range(0, 1);
      start_clear = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 149) == 0);
    end
    reset = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
